// File: rtl/times_two_8bit_serial.sv
// times_two_8bit_serial: bit-serial multiply-by-two with start/busy/done handshake.
// Optional macro TIMES_TWO_SATURATE_EN clamps OUT to all ones when the product overflows.
module times_two_8bit_serial #(
  parameter int WIDTH   = 8,
  parameter int PHASE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   OUT,
  output logic               OVF,
  output logic [PHASE_W-1:0] phase
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(WIDTH - 1);
  state_t           state;
  logic [WIDTH-1:0] src, acc, acc_next;
  // Move source bit `phase` into accumulator bit `phase+1`; the top bit falls off as overflow.
  always_comb acc_next = acc | ((src & (WIDTH'(1) << phase)) << 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      src   <= '0;
      acc   <= '0;
      phase <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      OUT   <= '0;
      OVF   <= 1'b0;
    end else if (state == S_SHIFT) begin
      acc <= acc_next;
      if (phase == LAST) begin
        state <= S_DONE;
        phase <= PHASE_W'(WIDTH);
        busy  <= 1'b0;
        done  <= 1'b1;
        OVF   <= src[WIDTH-1];
`ifdef TIMES_TWO_SATURATE_EN
        OUT   <= src[WIDTH-1] ? '1 : acc_next;
`else
        OUT   <= acc_next;
`endif
      end else begin
        phase <= phase + 1'b1;
      end
    end else if (start) begin
      state <= S_SHIFT;
      src   <= A;
      acc   <= '0;
      phase <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= S_IDLE;
      phase <= '0;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_times_two_8bit_serial.sv
// tb_times_two_8bit_serial: table, random and handshake corner checks for times_two_8bit_serial.
module tb_times_two_8bit_serial;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] A = '0;
  logic       busy, done, OVF;
  logic [7:0] OUT;
  logic [3:0] phase;
  int checks = 0, errors = 0;
  logic [7:0] prev_out = '0;

  times_two_8bit_serial dut (
    .clk(clk), .reset(reset), .start(start), .A(A),
    .busy(busy), .done(done), .OUT(OUT), .OVF(OVF), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] a; logic [7:0] o; logic v;} vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model_out(input logic [7:0] a);
    int p = int'(a) * 2;
`ifdef TIMES_TWO_SATURATE_EN
    return (p > 255) ? 8'd255 : 8'(p);
`else
    return 8'(p % 256);
`endif
  endfunction

  // One full operation; inj >= 0 pulses a (to be ignored) start with a different A at that phase.
  task automatic do_op(input logic [7:0] a, input logic [7:0] eo, input logic ev, input int inj);
    @(negedge clk); A = a; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("shift_busy", busy, 1);
      chk("shift_phase", phase, k);
      chk("shift_done", done, 0);
      chk("shift_out_hold", OUT, prev_out);
      if (k == inj) begin start = 1'b1; A = ~a; end
      if (k == inj + 1) start = 1'b0;
      @(negedge clk);
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_phase", phase, 8);
    chk("result_out", OUT, eo);
    chk("result_ovf", OVF, ev);
    prev_out = eo;
    @(negedge clk);
    chk("after_done", done, 0);
    chk("after_phase", phase, 0);
    chk("after_out", OUT, eo);
  endtask

  initial begin
    int cyc;
    logic [7:0] r;
    tbl[0] = '{8'd200, model_out(8'd200), 1'b1};
    tbl[1] = '{8'd0,   8'd0,   1'b0};
    tbl[2] = '{8'd255, model_out(8'd255), 1'b1};
    tbl[3] = '{8'd64,  8'd128, 1'b0};
    tbl[4] = '{8'd1,   8'd2,   1'b0};
    tbl[5] = '{8'd55,  8'd110, 1'b0};
    #100;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", OUT, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_phase", phase, 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 6; i++) do_op(tbl[i].a, tbl[i].o, tbl[i].v, -1);
    // start during SHIFT must be ignored; OUT keeps 110 until A=3 completes
    do_op(8'd3, 8'd6, 1'b0, 2);
    // asynchronous reset mid-operation
    @(negedge clk); A = 8'd129; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (phase != 4'd4 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("reach_phase4", phase, 4);
    #2 reset = 1'b1;
    #1;
    chk("async_out", OUT, 0);
    chk("async_busy", busy, 0);
    chk("async_phase", phase, 0);
    chk("async_ovf", OVF, 0);
    @(negedge clk); reset = 1'b0; prev_out = '0;
    do_op(8'd1, 8'd2, 1'b0, -1);
    // back-to-back with start held high
    @(negedge clk); A = 8'd64; start = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 20);
    chk("b2b_first_lat", cyc, 9);
    chk("b2b_first_out", OUT, 128);
    chk("b2b_first_ovf", OVF, 0);
    A = 8'd127;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) chk("b2b_busy_rises", busy, 1);
      if (cyc == 4) A = 8'd5;
    end while (!done && cyc < 20);
    start = 1'b0;
    chk("b2b_gap", cyc, 9);
    chk("b2b_second_out", OUT, 254);
    chk("b2b_second_ovf", OVF, 0);
    prev_out = 8'd254;
    @(negedge clk);
    chk("b2b_after_phase", phase, 0);
    // randomized operands against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      r = 8'($urandom_range(0, 255));
      do_op(r, model_out(r), r > 8'd127, (i % 3 == 0) ? int'($urandom_range(0, 5)) : -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
